// File: rtl/plru_repl_ctrl_pkg.sv
// Shared types for the pLRU replacement controller: FSM states, default geometry, tree type.
package plru_pkg;

    localparam int unsigned DEF_WAYS     = 4;
    localparam int unsigned DEF_NSETS    = 16;
    localparam int unsigned DEF_BITS_WAY = $clog2(DEF_WAYS);
    localparam int unsigned DEF_BITS_SET = $clog2(DEF_NSETS);

    typedef logic [DEF_WAYS-2:0] tree_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRBK,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/plru_repl_ctrl_if.sv
// Request/response channel between the cache tag stage (master) and the replacement controller (slave).
interface plru_repl_ctrl_if #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned NSETS = 16
);
    localparam int unsigned BITS_WAY = $clog2(WAYS);
    localparam int unsigned BITS_SET = $clog2(NSETS);

    logic                req_valid;
    logic                req_ready;
    logic [BITS_SET-1:0] req_set;
    logic                req_is_hit;
    logic [BITS_WAY-1:0] req_way;
    logic                rsp_valid;
    logic                rsp_is_miss;
    logic [BITS_WAY-1:0] rsp_victim;

    modport master (
        output req_valid, req_set, req_is_hit, req_way,
        input  req_ready, rsp_valid, rsp_is_miss, rsp_victim
    );

    modport slave (
        input  req_valid, req_set, req_is_hit, req_way,
        output req_ready, rsp_valid, rsp_is_miss, rsp_victim
    );

endinterface

// File: rtl/plru_repl_ctrl_tree_ram.sv
// Per-set pLRU tree storage: NSETS x TW flops, combinational read, synchronous write, async clear.
module plru_tree_ram #(
    parameter int unsigned NSETS = 16,
    parameter int unsigned TW    = 3,
    parameter int unsigned AW    = $clog2(NSETS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr_i,
    output logic [TW-1:0] rd_data_c,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [TW-1:0] wr_data_i
);

    logic [TW-1:0] mem_q [NSETS];

    assign rd_data_c = mem_q[rd_addr_i];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NSETS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/plru_repl_ctrl.sv
// Serialises hit-update / miss-victim requests onto one external pLRU engine and writes trees back.
// Optional PLRU_FLUSH_EN adds flush_req, which clears every set's tree one set per cycle.
module plru_repl_ctrl
    import plru_pkg::*;
#(
    parameter int unsigned WAYS  = DEF_WAYS,
    parameter int unsigned NSETS = DEF_NSETS,
    localparam int unsigned BITS_WAY = $clog2(WAYS),
    localparam int unsigned BITS_SET = $clog2(NSETS)
) (
    input  logic                clk,
    input  logic                rst,
    plru_repl_ctrl_if.slave     bus,
    output logic [BITS_WAY-1:0] eng_line_num,
    output logic [WAYS-2:0]     eng_btree_in,
    output logic [BITS_WAY:0]   eng_lines,
    output logic                eng_hit,
    output logic                eng_miss,
    input  logic [WAYS-2:0]     eng_btree_out,
    input  logic                eng_btree_valid,
    input  logic [BITS_WAY-1:0] eng_index,
    input  logic                eng_busy
`ifdef PLRU_FLUSH_EN
    ,
    input  logic                flush_req
`endif
);

    state_e              state_q;
    logic [BITS_SET-1:0] set_q;
    logic                is_hit_q;
    logic [BITS_WAY-1:0] way_q;
    logic [WAYS-2:0]     tree_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic                rsp_is_miss_q;
    logic [BITS_WAY-1:0] rsp_victim_q;
    logic                eng_hit_q;
    logic                eng_miss_q;
    logic [BITS_WAY-1:0] eng_line_num_q;
    logic [WAYS-2:0]     eng_btree_in_q;

    logic [WAYS-2:0]     rd_tree_c;
    logic                wr_en_c;
    logic [BITS_SET-1:0] wr_addr_c;
    logic [WAYS-2:0]     wr_data_c;

`ifdef PLRU_FLUSH_EN
    logic [BITS_SET-1:0] flush_cnt_q;

    // Flush sweeps share the single write port with the WRBK write-back.
    assign wr_en_c   = (state_q == ST_WRBK) || (state_q == ST_FLUSH);
    assign wr_addr_c = (state_q == ST_FLUSH) ? flush_cnt_q : set_q;
    assign wr_data_c = (state_q == ST_FLUSH) ? '0 : tree_q;
`else
    assign wr_en_c   = (state_q == ST_WRBK);
    assign wr_addr_c = set_q;
    assign wr_data_c = tree_q;
`endif

    plru_tree_ram #(
        .NSETS (NSETS),
        .TW    (WAYS - 1),
        .AW    (BITS_SET)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_i (set_q),
        .rd_data_c (rd_tree_c),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (wr_addr_c),
        .wr_data_i (wr_data_c)
    );

    // Controller FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            set_q          <= '0;
            is_hit_q       <= 1'b0;
            way_q          <= '0;
            tree_q         <= '0;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_is_miss_q  <= 1'b0;
            rsp_victim_q   <= '0;
            eng_hit_q      <= 1'b0;
            eng_miss_q     <= 1'b0;
            eng_line_num_q <= '0;
            eng_btree_in_q <= '0;
`ifdef PLRU_FLUSH_EN
            flush_cnt_q    <= '0;
`endif
        end else begin
            eng_hit_q   <= 1'b0;
            eng_miss_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
`ifdef PLRU_FLUSH_EN
                    if (flush_req) begin
                        state_q     <= ST_FLUSH;
                        req_ready_q <= 1'b0;
                        flush_cnt_q <= '0;
                    end else
`endif
                    if (bus.req_valid) begin
                        state_q     <= ST_ISSUE;
                        req_ready_q <= 1'b0;
                        set_q       <= bus.req_set;
                        is_hit_q    <= bus.req_is_hit;
                        way_q       <= bus.req_way;
                    end
                end
                ST_ISSUE: begin
                    // A stale result still on the bus would be mistaken for ours in WAIT.
                    if (!eng_busy && !eng_btree_valid) begin
                        eng_hit_q      <= is_hit_q;
                        eng_miss_q     <= !is_hit_q;
                        eng_btree_in_q <= rd_tree_c;
                        eng_line_num_q <= way_q;
                        state_q        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (eng_btree_valid) begin
                        tree_q        <= eng_btree_out;
                        rsp_valid_q   <= 1'b1;
                        rsp_is_miss_q <= !is_hit_q;
                        if (!is_hit_q) begin
                            rsp_victim_q <= eng_index;
                        end
                        state_q       <= ST_WRBK;
                    end
                end
                ST_WRBK: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
`ifdef PLRU_FLUSH_EN
                ST_FLUSH: begin
                    flush_cnt_q <= flush_cnt_q + BITS_SET'(1);
                    if (flush_cnt_q == BITS_SET'(NSETS - 1)) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_is_miss = rsp_is_miss_q;
    assign bus.rsp_victim  = rsp_victim_q;
    assign eng_hit         = eng_hit_q;
    assign eng_miss        = eng_miss_q;
    assign eng_line_num    = eng_line_num_q;
    assign eng_btree_in    = eng_btree_in_q;
    assign eng_lines       = (BITS_WAY + 1)'(WAYS);

endmodule
